led_trail_pwm: RTL and testbench
================================

// Module: led_trail_pwm
// PURPOSE
//   Downstream stage of the knight-rider pattern generator. Takes its raw WIDTH-bit LED pattern and drives
//   each LED with a PWM brightness that snaps to full when the pattern bit is set, then decays step by
//   step after it clears. The result is a fading comet trail. Sits between the pattern generator and the pads.
// PARAMETERS
//   WIDTH       8   number of LEDs (pattern width)
//   LEVEL_BITS  4   brightness resolution; MAX = 2**LEVEL_BITS-1; PWM period = 2**LEVEL_BITS clk_src cycles
// PORTS
//   clk_src    in   1           single system clock; all logic on posedge
//   reset_n    in   1           synchronous, active-low reset
//   led_in     in   WIDTH       raw pattern from the knight-rider stage (slow-changing, divided-clock domain)
//   decay_div  in   16          decay-step period minus one, in clk_src cycles
//   led_out    out  WIDTH       PWM-modulated LED drive, registered
// BEHAVIOUR
//   - Reset (reset_n=0 at posedge): led_out, all level[i], pwm_cnt, pre_cnt and sync flops <= 0.
//     Reset mid-decay clears everything on the next edge. There is no partial state.
//   - Input sync: led_in passes through a 2-flop synchronizer -> led_s (see CONFIGURATION).
//   - pwm_cnt [LEVEL_BITS]: free-running +1 per cycle, wraps MAX->0.
//   - Prescaler pre_cnt [16]:
//       - if pre_cnt >= decay_div: tick=1, pre_cnt<=0; else pre_cnt<=pre_cnt+1.
//       - decay_div=0 gives a tick every cycle.
//       - A decay_div change takes effect immediately. If pre_cnt already exceeds the new value, tick fires next cycle.
//   - Per LED, level[i] [LEVEL_BITS], updated each cycle:
//       - led_s[i]=1            -> level[i] <= MAX (wins over a simultaneous tick)
//       - else tick && level>0  -> level[i] <= level[i]-1
//       - else                  -> hold; saturates at 0, never wraps below 0.
//   - Output register: led_out[i] <= (level[i]==MAX) | (level[i] > pwm_cnt).
//       - MAX = solid on.
//       - 0 = solid off.
//       - otherwise high for level[i] of every 2**LEVEL_BITS cycles.
//   - Latency: led_in rise -> led_out solid high = 4 clk_src edges (2 sync + level + out).
//   - Decay from MAX to 0 after led_in falls = MAX ticks = MAX*(decay_div+1) cycles, plus sync latency.
//   - All LEDs are independent. The prescaler and pwm_cnt are shared, so all LEDs decay in lockstep phase.
//   - A glitch-free pulse on led_in shorter than one clk_src cycle may be missed. This is acceptable;
//     the source is a divided clock.
// CONFIGURATION
//   LED_TRAIL_SYNC_EN defined (default build flow): 2-flop synchronizer present, latency 4 as above.
//   LED_TRAIL_SYNC_EN undefined: led_s = led_in directly (source must be clk_src-synchronous).
//     led_in->led_out latency becomes 2 edges. Everything else is identical.
// TESTING  (WIDTH=8, LEVEL_BITS=4, LED_TRAIL_SYNC_EN defined unless noted)
//   1. reset_n=0 for 5 cycles, led_in=8'hFF -> led_out=8'h00 throughout; levels 0 on release.
//   2. reset_n=1, decay_div=3, led_in 8'h00->8'h01 -> led_out=8'h01 solid from 4th edge; led_out[7:1]=0.
//   3. From (2), led_in->8'h00 -> level[0] drops by 1 every 4 cycles.
//      - At level 8: led_out[0] high exactly 8 of each 16 cycles.
//      - level 0 reached at 60+2 cycles, then led_out=0 forever.
//   4. decay_div=0, led_in pulse 8'h80 then 8'h00 -> level[7] steps 15..0 on consecutive cycles;
//      led_out[7] low for good within 18 cycles.
//   5. led_in[3]=1 held while ticks occur (decay_div=0) -> level[3] stays 15; led_out[3] never drops.
//   6. Mid-decay (level[0]=9), pulse reset_n=0 one cycle -> next edge led_out=0, levels=0, pwm_cnt=0.
//      Repeat 2 with LED_TRAIL_SYNC_EN undefined -> led_out[0] solid from 2nd edge.

Source files
------------

// File: rtl/led_trail_pwm_if.sv
// LED trail PWM bus: raw pattern and decay period in, modulated LED drive out.
interface led_trail_pwm_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] led_in;
    logic [15:0]      decay_div;
    logic [WIDTH-1:0] led_out;

    modport master (output led_in, output decay_div, input led_out);
    modport slave  (input led_in, input decay_div, output led_out);
endinterface

// File: rtl/led_trail_pwm.sv
// Comet-trail PWM stage: each LED snaps to full brightness, then decays one level per prescaler tick.
// Build option LED_TRAIL_SYNC_EN adds a 2-flop input synchronizer (latency 4 instead of 2).
module led_trail_pwm #(
    parameter int WIDTH      = 8,
    parameter int LEVEL_BITS = 4
) (
    input  logic              clk_src,
    input  logic              reset_n,
    led_trail_pwm_if.slave    bus
);
    localparam logic [LEVEL_BITS-1:0] MAX = '1;

    logic [WIDTH-1:0]                 led_s;
    logic [LEVEL_BITS-1:0]            pwm_cnt_q, pwm_cnt_d;
    logic [15:0]                      pre_cnt_q, pre_cnt_d;
    logic                             tick;
    logic [WIDTH-1:0][LEVEL_BITS-1:0] level_q, level_d;
    logic [WIDTH-1:0]                 led_out_q, led_out_d;

`ifdef LED_TRAIL_SYNC_EN
    logic [WIDTH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_src) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.led_in;
            sync2_q <= sync1_q;
        end
    end

    assign led_s = sync2_q;
`else
    assign led_s = bus.led_in;
`endif

    // '>=' so that lowering decay_div below the running count fires a tick right away
    always_comb begin
        tick      = (pre_cnt_q >= bus.decay_div);
        pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
        pwm_cnt_d = pwm_cnt_q + LEVEL_BITS'(1);
        level_d   = level_q;
        led_out_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (led_s[i]) begin
                level_d[i] = MAX;
            end else if (tick && (level_q[i] != '0)) begin
                level_d[i] = level_q[i] - LEVEL_BITS'(1);
            end
            led_out_d[i] = (level_q[i] == MAX) || (level_q[i] > pwm_cnt_q);
        end
    end

    always_ff @(posedge clk_src) begin
        if (!reset_n) begin
            pwm_cnt_q <= '0;
            pre_cnt_q <= '0;
            level_q   <= '0;
            led_out_q <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            level_q   <= level_d;
            led_out_q <= led_out_d;
        end
    end

    assign bus.led_out = led_out_q;
endmodule

// File: tb/tb_led_trail_pwm.sv
// Directed self-checking bench for led_trail_pwm (WIDTH=8, LEVEL_BITS=4).
module tb_led_trail_pwm;
`ifdef LED_TRAIL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic clk_src = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cnt;
    int   k;
    int   lvl;
    logic exp_bit;

    led_trail_pwm_if #(.WIDTH(8)) bus ();

    led_trail_pwm #(.WIDTH(8), .LEVEL_BITS(4)) dut (
        .clk_src (clk_src),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk_src = ~clk_src;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset held with all inputs high: outputs stay dark
        reset_n       = 1'b0;
        bus.led_in    = 8'hFF;
        bus.decay_div = 16'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_src);
            chk("rst_out", {24'd0, bus.led_out}, 32'h0);
        end
        chk("rst_pwm", {28'd0, dut.pwm_cnt_q}, 32'h0);
        chk("rst_lvl", dut.level_q, 32'h0);

        // release; edge k leaves pwm_cnt = k%16 and ticks on edges k%4==0
        bus.led_in = 8'h00;
        reset_n    = 1'b1;
        repeat (3) @(negedge clk_src);
        chk("idle_out", {24'd0, bus.led_out}, 32'h0);

        bus.led_in = 8'h01;
        repeat (LAT - 1) @(negedge clk_src);
        chk("rise_early", {24'd0, bus.led_out}, 32'h0);
        @(negedge clk_src);
        chk("rise_solid", {24'd0, bus.led_out}, 32'h01);
        for (int j = 4 + LAT; j <= 12; j++) begin
            @(negedge clk_src);
            chk("hold_solid", {24'd0, bus.led_out}, 32'h01);
        end

        // drop after edge 12: level after edge k is 18-k/4 (k=12..72), output at edge k+1
        bus.led_in = 8'h00;
        for (int j = 13; j <= 100; j++) begin
            @(negedge clk_src);
            k       = j - 1;
            lvl     = (k > 72) ? 0 : 18 - k / 4;
            exp_bit = (lvl == 15) || (lvl > (k % 16));
            chk("decay_pwm", {24'd0, bus.led_out}, {31'd0, exp_bit});
        end

        // one-cycle pulse on LED7 with a tick every cycle
        bus.decay_div = 16'd0;
        @(negedge clk_src);
        bus.led_in = 8'h80;
        @(negedge clk_src);
        bus.led_in = 8'h00;
        repeat (LAT - 1) @(negedge clk_src);
        chk("fast_on", {24'd0, bus.led_out}, 32'h80);
        repeat (14) @(negedge clk_src);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_src);
            chk("fast_off", {24'd0, bus.led_out}, 32'h0);
        end

        // held input beats every tick
        bus.led_in = 8'h08;
        repeat (LAT) @(negedge clk_src);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_src);
            chk("held_on", {24'd0, bus.led_out}, 32'h08);
        end
        bus.led_in = 8'h00;
        repeat (25) @(negedge clk_src);
        chk("held_release", {24'd0, bus.led_out}, 32'h0);

        // park LED0 at level 9: six single-cycle ticks, then freeze the prescaler
        bus.led_in = 8'h01;
        repeat (LAT + 2) @(negedge clk_src);
        bus.decay_div = 16'hFFFF;
        bus.led_in    = 8'h00;
        repeat (5) @(negedge clk_src);
        chk("park_full", {24'd0, bus.led_out}, 32'h01);
        bus.decay_div = 16'd0;
        repeat (6) @(negedge clk_src);
        bus.decay_div = 16'hFFFF;
        chk("park_lvl", {28'd0, dut.level_q[0]}, 32'd9);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_src);
            cnt += int'(bus.led_out[0]);
        end
        chk("duty_9of16", cnt, 32'd9);
        chk("duty_lvl", {28'd0, dut.level_q[0]}, 32'd9);

        // one-cycle reset mid-decay wipes everything on that edge
        reset_n = 1'b0;
        @(negedge clk_src);
        chk("midrst_out", {24'd0, bus.led_out}, 32'h0);
        chk("midrst_lvl", dut.level_q, 32'h0);
        chk("midrst_pwm", {28'd0, dut.pwm_cnt_q}, 32'h0);
        reset_n       = 1'b1;
        bus.decay_div = 16'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_src);
            chk("post_rst", {24'd0, bus.led_out}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
